// File: rtl/score_keeper_if.sv
// Ball object type shared with the ball stage, and the bus joining the ball
// stage / player controls to score_keeper.
package object_package;
  localparam int FBITS = 8;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [15:0] width;
    logic [15:0] height;
  } object;
endpackage

interface score_keeper_if;
  import object_package::*;

  logic        tick;
  logic        start;
  object       ball1;
  object       ball2;
  logic        play_en;
  logic [3:0]  score_left;
  logic [3:0]  score_right;
  logic        goal_left;
  logic        goal_right;
  logic        gameover;
  logic [1:0]  winner;
  logic [2:0]  state;

  modport master (
    output tick, start, ball1, ball2,
    input  play_en, score_left, score_right, goal_left, goal_right,
           gameover, winner, state
  );

  modport slave (
    input  tick, start, ball1, ball2,
    output play_en, score_left, score_right, goal_left, goal_right,
           gameover, winner, state
  );
endinterface

// File: rtl/score_keeper.sv
// Match control: detects balls leaving the screen, keeps scores, runs the
// serve/respawn sequence and gates the ball stage through play_en.
module score_keeper #(
  parameter logic [31:0] SCREEN_WIDTH = 32'(640) << object_package::FBITS,
  parameter int unsigned WIN_SCORE    = 7,
  parameter int unsigned SERVE_TICKS  = 60
) (
  input logic          clk,
  input logic          rst,
  score_keeper_if.slave bus
);
  import object_package::*;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SERVE    = 3'd1,
    ST_PLAY     = 3'd2,
    ST_RESPAWN  = 3'd3,
    ST_GAMEOVER = 3'd4
  } state_t;

  localparam logic [3:0] WIN4  = 4'(WIN_SCORE);
  localparam logic [4:0] WIN5  = 5'(WIN_SCORE);
  localparam logic [7:0] SERVE = 8'(SERVE_TICKS);

  state_t     state_q, state_d;
  logic       play_en_q, play_en_d;
  logic [7:0] cnt_q, cnt_d;
  logic       start_q, start_d;
  logic [3:0] score_l_q, score_l_d, score_r_q, score_r_d;
  logic       goal_l_q, goal_l_d, goal_r_q, goal_r_d;
  logic       gameover_q, gameover_d;
  logic [1:0] winner_q, winner_d;
  logic [1:0] in_prev_q, in_prev_d;
  logic [1:0] side_q, side_d;

  object      balls [2];
  logic [1:0] ball_out, left_half, goal;
  logic [1:0] inc_l, inc_r;
  logic [4:0] sum_l, sum_r;
  logic [3:0] new_l, new_r;
  logic       win_l, win_r, any_goal, over, start_edge;

  always_comb begin
    balls[0] = bus.ball1;
    balls[1] = bus.ball2;
    ball_out  = '0;
    left_half = '0;
    goal      = '0;
    for (int unsigned b = 0; b < 2; b++) begin
      // Exiting left wraps x to a huge value, so one unsigned compare catches both exits.
      ball_out[b]  = balls[b].x > SCREEN_WIDTH;
      left_half[b] = (balls[b].x + 32'(balls[b].width >> 1)) < (SCREEN_WIDTH >> 1);
      goal[b]      = ball_out[b] && in_prev_q[b] &&
                     (state_q == ST_PLAY || state_q == ST_RESPAWN);
    end
    inc_l      = {1'b0, goal[0] & ~side_q[0]} + {1'b0, goal[1] & ~side_q[1]};
    inc_r      = {1'b0, goal[0] &  side_q[0]} + {1'b0, goal[1] &  side_q[1]};
    sum_l      = {1'b0, score_l_q} + {3'b0, inc_l};
    sum_r      = {1'b0, score_r_q} + {3'b0, inc_r};
    new_l      = (sum_l >= WIN5) ? WIN4 : sum_l[3:0];
    new_r      = (sum_r >= WIN5) ? WIN4 : sum_r[3:0];
    win_l      = (new_l == WIN4);
    win_r      = (new_r == WIN4);
    any_goal   = |goal;
    over       = any_goal && (win_l || win_r);
    start_edge = bus.start && !start_q;
  end

  always_comb begin
    state_d    = state_q;
    play_en_d  = play_en_q;
    cnt_d      = cnt_q;
    start_d    = start_q;
    score_l_d  = score_l_q;
    score_r_d  = score_r_q;
    goal_l_d   = 1'b0;
    goal_r_d   = 1'b0;
    gameover_d = gameover_q;
    winner_d   = winner_q;
    in_prev_d  = in_prev_q;
    side_d     = side_q;

    if (bus.tick) begin
      start_d = bus.start;
      for (int unsigned b = 0; b < 2; b++) begin
        if (!ball_out[b]) begin
          in_prev_d[b] = 1'b1;
          side_d[b]    = left_half[b];
        end else if (goal[b]) begin
          in_prev_d[b] = 1'b0;
        end
      end

      if (any_goal) begin
        score_l_d = new_l;
        score_r_d = new_r;
        goal_l_d  = (inc_l != 2'd0);
        goal_r_d  = (inc_r != 2'd0);
        if (over) begin
          gameover_d = 1'b1;
          winner_d   = {win_r, win_l};
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (start_edge) begin
            state_d = ST_SERVE;
            cnt_d   = SERVE;
          end
        end
        ST_SERVE: begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q <= 8'd1) state_d = ST_PLAY;
        end
        ST_PLAY: begin
          if (over)          state_d = ST_GAMEOVER;
          else if (any_goal) state_d = ST_RESPAWN;
        end
        ST_RESPAWN: begin
          if (over) begin
            state_d = ST_GAMEOVER;
          end else begin
            state_d = ST_SERVE;
            cnt_d   = SERVE;
          end
        end
        ST_GAMEOVER: begin
          if (start_edge) begin
            score_l_d  = '0;
            score_r_d  = '0;
            winner_d   = '0;
            gameover_d = 1'b0;
            in_prev_d  = '1;
            state_d    = ST_SERVE;
            cnt_d      = SERVE;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      // Registered from the next state so the ball stage sees it for the whole next tick.
      play_en_d = (state_d == ST_PLAY) || (state_d == ST_RESPAWN);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      play_en_q  <= 1'b0;
      cnt_q      <= '0;
      start_q    <= 1'b0;
      score_l_q  <= '0;
      score_r_q  <= '0;
      goal_l_q   <= 1'b0;
      goal_r_q   <= 1'b0;
      gameover_q <= 1'b0;
      winner_q   <= '0;
      in_prev_q  <= '1;
      side_q     <= '0;
    end else begin
      state_q    <= state_d;
      play_en_q  <= play_en_d;
      cnt_q      <= cnt_d;
      start_q    <= start_d;
      score_l_q  <= score_l_d;
      score_r_q  <= score_r_d;
      goal_l_q   <= goal_l_d;
      goal_r_q   <= goal_r_d;
      gameover_q <= gameover_d;
      winner_q   <= winner_d;
      in_prev_q  <= in_prev_d;
      side_q     <= side_d;
    end
  end

  assign bus.play_en     = play_en_q;
  assign bus.score_left  = score_l_q;
  assign bus.score_right = score_r_q;
  assign bus.goal_left   = goal_l_q;
  assign bus.goal_right  = goal_r_q;
  assign bus.gameover    = gameover_q;
  assign bus.winner      = winner_q;
  assign bus.state       = state_q;

  logic unused_ok;
  assign unused_ok = ^{bus.ball1.y, bus.ball1.height, bus.ball1.width[0],
                       bus.ball2.y, bus.ball2.height, bus.ball2.width[0]};
endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: a vector table for the opening serve and
// single goals, then hand sequences for saturation, draw, restart and reset.
module tb_score_keeper;
  import object_package::*;

  localparam logic [31:0] X_R_IN  = 32'(600) << FBITS;
  localparam logic [31:0] X_R_OUT = 32'(700) << FBITS;
  localparam logic [31:0] X_L_IN  = 32'(20)  << FBITS;
  localparam logic [31:0] X_CTR   = 32'(300) << FBITS;
  localparam logic [31:0] X_L_OUT = 32'hFFFF_FFF0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  score_keeper_if bus();

  score_keeper #(.WIN_SCORE(7), .SERVE_TICKS(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_pass  = 0;
  int n_total = 0;
  int exp_l   = 0;
  int exp_r   = 0;

  typedef struct {
    logic [31:0] b1x;
    logic [31:0] b2x;
    logic        start;
    logic [2:0]  st;
    logic        pe;
    logic [3:0]  sl;
    logic [3:0]  sr;
    logic        gl;
    logic        gr;
    logic        go;
    logic [1:0]  win;
  } vec_t;

  vec_t vecs [17];

  function automatic object mk(input logic [31:0] x);
    object o;
    o.x      = x;
    o.y      = 32'(100) << FBITS;
    o.width  = 16'(8 << FBITS);
    o.height = 16'(8 << FBITS);
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic chk_all(input string tag, input logic [2:0] st, input logic pe,
                         input logic [3:0] sl, input logic [3:0] sr, input logic gl,
                         input logic gr, input logic go, input logic [1:0] win);
    chk({tag, ".state"},       32'(bus.state),       32'(st));
    chk({tag, ".play_en"},     32'(bus.play_en),     32'(pe));
    chk({tag, ".score_left"},  32'(bus.score_left),  32'(sl));
    chk({tag, ".score_right"}, 32'(bus.score_right), 32'(sr));
    chk({tag, ".goal_left"},   32'(bus.goal_left),   32'(gl));
    chk({tag, ".goal_right"},  32'(bus.goal_right),  32'(gr));
    chk({tag, ".gameover"},    32'(bus.gameover),    32'(go));
    chk({tag, ".winner"},      32'(bus.winner),      32'(win));
  endtask

  task automatic do_tick();
    @(negedge clk);
    bus.tick = 1'b1;
    @(posedge clk);
    #1;
    bus.tick = 1'b0;
  endtask

  task automatic score_goal(input bit left);
    if (left) begin
      bus.ball1 = mk(X_R_IN);
      do_tick();
      bus.ball1 = mk(X_R_OUT);
      do_tick();
      exp_l++;
      chk_all("goal_l_seq", 3'd3, 1'b1, 4'(exp_l), 4'(exp_r), 1'b1, 1'b0, 1'b0, 2'd0);
      bus.ball1 = mk(X_R_IN);
    end else begin
      bus.ball2 = mk(X_L_IN);
      do_tick();
      bus.ball2 = mk(X_L_OUT);
      do_tick();
      exp_r++;
      chk_all("goal_r_seq", 3'd3, 1'b1, 4'(exp_l), 4'(exp_r), 1'b0, 1'b1, 1'b0, 2'd0);
      bus.ball2 = mk(X_L_IN);
    end
    do_tick();
    chk("respawn_to_serve", 32'(bus.state), 32'd1);
    repeat (3) do_tick();
    chk("serve_to_play", 32'(bus.state), 32'd2);
  endtask

  initial begin
    //          b1x      b2x      st  state pe  sl  sr  gl  gr  go  win
    vecs[0]  = '{X_R_IN,  X_L_IN,  1'b1, 3'd1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[1]  = '{X_R_IN,  X_L_IN,  1'b1, 3'd1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[2]  = '{X_R_IN,  X_L_IN,  1'b0, 3'd1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[3]  = '{X_R_IN,  X_L_IN,  1'b0, 3'd2, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[4]  = '{X_R_IN,  X_L_IN,  1'b0, 3'd2, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[5]  = '{X_R_OUT, X_L_IN,  1'b0, 3'd3, 1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 1'b0, 2'd0};
    vecs[6]  = '{X_R_OUT, X_L_IN,  1'b0, 3'd1, 1'b0, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[7]  = '{X_R_OUT, X_L_IN,  1'b0, 3'd1, 1'b0, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[8]  = '{X_R_OUT, X_L_IN,  1'b0, 3'd1, 1'b0, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[9]  = '{X_R_OUT, X_L_IN,  1'b0, 3'd2, 1'b1, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[10] = '{X_R_OUT, X_L_IN,  1'b0, 3'd2, 1'b1, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[11] = '{X_CTR,   X_L_IN,  1'b1, 3'd2, 1'b1, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[12] = '{X_CTR,   X_L_OUT, 1'b0, 3'd3, 1'b1, 4'd1, 4'd1, 1'b0, 1'b1, 1'b0, 2'd0};
    vecs[13] = '{X_CTR,   X_L_IN,  1'b0, 3'd1, 1'b0, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[14] = '{X_CTR,   X_L_IN,  1'b0, 3'd1, 1'b0, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[15] = '{X_CTR,   X_L_IN,  1'b0, 3'd1, 1'b0, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[16] = '{X_CTR,   X_L_IN,  1'b0, 3'd2, 1'b1, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0, 2'd0};

    rst       = 1'b1;
    bus.tick  = 1'b0;
    bus.start = 1'b0;
    bus.ball1 = mk(X_R_IN);
    bus.ball2 = mk(X_L_IN);
    @(posedge clk);
    #1;
    chk_all("reset", 3'd0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      bus.ball1 = mk(vecs[i].b1x);
      bus.ball2 = mk(vecs[i].b2x);
      bus.start = vecs[i].start;
      do_tick();
      chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].pe, vecs[i].sl, vecs[i].sr,
              vecs[i].gl, vecs[i].gr, vecs[i].go, vecs[i].win);
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d_notick", i), vecs[i].st, vecs[i].pe, vecs[i].sl, vecs[i].sr,
              1'b0, 1'b0, vecs[i].go, vecs[i].win);
    end
    exp_l = 1;
    exp_r = 1;

    // Left to 5, then both balls exit right together: 5 + 2 saturates at 7.
    repeat (4) score_goal(1'b1);
    bus.ball1 = mk(X_R_IN);
    bus.ball2 = mk(X_R_IN);
    do_tick();
    chk("pre_simul.state", 32'(bus.state), 32'd2);
    bus.ball1 = mk(X_R_OUT);
    bus.ball2 = mk(X_R_OUT);
    do_tick();
    chk_all("simul", 3'd4, 1'b0, 4'd7, 4'd1, 1'b1, 1'b0, 1'b1, 2'd1);
    do_tick();
    chk_all("gameover_hold", 3'd4, 1'b0, 4'd7, 4'd1, 1'b0, 1'b0, 1'b1, 2'd1);

    bus.ball1 = mk(X_R_IN);
    bus.ball2 = mk(X_L_IN);
    bus.start = 1'b1;
    do_tick();
    chk_all("restart", 3'd1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0);
    exp_l = 0;
    exp_r = 0;
    bus.start = 1'b0;
    repeat (3) do_tick();
    chk("restart_play.state", 32'(bus.state), 32'd2);

    repeat (6) begin
      score_goal(1'b1);
      score_goal(1'b0);
    end
    bus.ball1 = mk(X_R_OUT);
    bus.ball2 = mk(X_L_OUT);
    do_tick();
    chk_all("draw", 3'd4, 1'b0, 4'd7, 4'd7, 1'b1, 1'b1, 1'b1, 2'd3);

    bus.ball1 = mk(X_R_IN);
    bus.ball2 = mk(X_L_IN);
    bus.start = 1'b1;
    do_tick();
    chk_all("restart2", 3'd1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0);
    do_tick();
    chk("start_held.state", 32'(bus.state), 32'd1);

    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_all("rst_serve", 3'd0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    // start is still high; the edge register was cleared, so this is a fresh edge.
    do_tick();
    chk_all("post_rst_start", 3'd1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
